// File: rtl/dds_uart_pkg.sv
// dds_uart_pkg: shared types and constants for the DDS-board UART transmit arbiter.
//   arb_state_e      - arbiter FSM states (idle / waiting for uart done / inter-byte gap)
//   UART_BYTE_W      - width of one UART byte
//   TIMEOUT_DEFAULT  - default send-to-done watchdog limit in clocks
package dds_uart_pkg;

    localparam int UART_BYTE_W     = 8;
    localparam int TIMEOUT_DEFAULT = 8192;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   in  N   request vector
//   ptr   in  IW  index with highest priority this round
//   grant out N   one-hot grant (0 when no request)
//   idx   out IW  index of the granted requester (0 when no request)
//   any   out 1   at least one request present
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] idx_lo;
    logic [IW-1:0] idx_hi;
    logic          hit_hi;

    // Two searches: lowest request at/above ptr, and lowest overall (the wrap case).
    // Scanning downward leaves the lowest matching index in each result.
    always_comb begin
        idx_lo = '0;
        idx_hi = '0;
        hit_hi = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_lo = IW'(i);
                if (IW'(i) >= ptr) begin
                    idx_hi = IW'(i);
                    hit_hi = 1'b1;
                end
            end
        end
    end

    assign any   = |req;
    assign idx   = hit_hi ? idx_hi : idx_lo;
    assign grant = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ byte producers.
// Round-robin per byte, optional packet lock (requester keeps the grant while
// its accepted byte carried req_lock), optional idle gap after each byte.
// Optional watchdog enabled by defining UART_ARB_TIMEOUT_EN.
//   clock, reset          system clock, synchronous active-high reset
//   req_valid/data/lock   per-requester byte offer (data of i at [8*i+7:8*i])
//   req_ready             1-clock pulse: byte of requester i accepted
//   req_done              1-clock pulse: byte of requester i shifted out
//   busy                  high from accept until back in idle
//   uart_send, uart_data  send pulse and held byte to the UART
//   uart_done             done pulse from the UART
//   timeout_err           1-clock pulse on watchdog abort (0 without UART_ARB_TIMEOUT_EN)
module uart_tx_arbiter
    import dds_uart_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 0,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_lock,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         req_done,
    output logic                     busy,
    output logic                     uart_send,
    output logic [UART_BYTE_W-1:0]   uart_data,
    input  logic                     uart_done,
    output logic                     timeout_err
);

    localparam int IW = $clog2(N_REQ);

    arb_state_e             state_q, state_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic                   lock_q, lock_d;          // owner holds the packet lock
    logic                   lock_acc_q, lock_acc_d;  // req_lock of the byte in flight
    logic [UART_BYTE_W-1:0] data_q, data_d;
    logic [N_REQ-1:0]       ready_q, ready_d;
    logic [N_REQ-1:0]       done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   send_q, send_d;
    logic [7:0]             gap_q, gap_d;
`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]            tmo_q, tmo_d;
    logic                   terr_q, terr_d;
`endif

    logic [N_REQ-1:0]       pick_grant;
    logic [IW-1:0]          pick_idx;
    logic                   pick_any;
    logic                   lock_hit;
    logic [IW-1:0]          win_idx;
    logic [N_REQ-1:0]       win_onehot;
    logic [IW-1:0]          ptr_inc;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A locked owner that is still offering a byte beats the rr pointer.
    assign lock_hit   = lock_q && req_valid[owner_q];
    assign win_idx    = lock_hit ? owner_q : pick_idx;
    assign win_onehot = lock_hit ? (N_REQ'(1) << owner_q) : pick_grant;
    assign ptr_inc    = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        lock_acc_d = lock_acc_q;
        data_d     = data_q;
        ready_d    = '0;
        done_d     = '0;
        busy_d     = busy_q;
        send_d     = 1'b0;
        gap_d      = gap_q;
`ifdef UART_ARB_TIMEOUT_EN
        tmo_d      = tmo_q;
        terr_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                // Owner withdrew between packets: lock is gone.
                if (lock_q && !req_valid[owner_q]) begin
                    lock_d = 1'b0;
                end
                if (pick_any) begin
                    owner_d    = win_idx;
                    lock_acc_d = req_lock[win_idx];
                    data_d     = req_data[{win_idx, 3'b000} +: UART_BYTE_W];
                    ready_d    = win_onehot;
                    send_d     = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                    tmo_d      = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (uart_done) begin
                    done_d = N_REQ'(1) << owner_q;
                    if (lock_acc_q) begin
                        lock_d = 1'b1;
                    end else begin
                        lock_d = 1'b0;
                        ptr_d  = ptr_inc;
                    end
                    if (GAP_CYCLES > 0) begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (tmo_q == 16'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    lock_d  = 1'b0;
                    ptr_d   = ptr_inc;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`endif
            end
            ST_GAP: begin
                if (gap_q == 8'(GAP_CYCLES - 1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            lock_q     <= 1'b0;
            lock_acc_q <= 1'b0;
            data_q     <= '0;
            ready_q    <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            send_q     <= 1'b0;
            gap_q      <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_q      <= '0;
            terr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            lock_q     <= lock_d;
            lock_acc_q <= lock_acc_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            send_q     <= send_d;
            gap_q      <= gap_d;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_q      <= tmo_d;
            terr_q     <= terr_d;
`endif
        end
    end

    assign req_ready = ready_q;
    assign req_done  = done_q;
    assign busy      = busy_q;
    assign uart_send = send_q;
    assign uart_data = data_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed stimulus, a per-edge transaction model
// (edge-number bookkeeping plus a plain round-robin search) compared against
// the DUT every cycle, and literal checks on the directed scenarios.
// A second instance with GAP_CYCLES=5 covers the inter-byte gap timing.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int GAP = 0;
    localparam int TMO = 100;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid, req_lock, req_ready, req_done;
    logic [8*N-1:0]   req_data;
    logic             busy, uart_send, uart_done, timeout_err;
    logic [7:0]       uart_data;

    logic [N-1:0]     g_valid, g_lock, g_ready, g_done_o;
    logic [8*N-1:0]   g_data;
    logic             g_busy, g_send, g_done, g_terr;
    logic [7:0]       g_udata;

    always #5 clock = ~clock;

    uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_lock(req_lock), .req_ready(req_ready), .req_done(req_done), .busy(busy),
        .uart_send(uart_send), .uart_data(uart_data), .uart_done(uart_done),
        .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(5), .TIMEOUT(TMO)) dut_gap (
        .clock(clock), .reset(reset), .req_valid(g_valid), .req_data(g_data),
        .req_lock(g_lock), .req_ready(g_ready), .req_done(g_done_o), .busy(g_busy),
        .uart_send(g_send), .uart_data(g_udata), .uart_done(g_done),
        .timeout_err(g_terr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- requester queues ----------------
    logic [8:0] qmem [N][32];
    int qh [N] = '{default: 0};
    int qt [N] = '{default: 0};

    task automatic push(input int i, input logic lk, input logic [7:0] d);
        qmem[i][qt[i] % 32] = {lk, d};
        qt[i]++;
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (qh[i] != qt[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Each requester offers its queue head and pops it on req_ready.
    initial begin
        req_valid = '0; req_data = '0; req_lock = '0;
        forever begin
            @(posedge clock); #1;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && qh[i] != qt[i]) qh[i]++;
                if (qh[i] != qt[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = qmem[i][qh[i] % 32][7:0];
                    req_lock[i]        = qmem[i][qh[i] % 32][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_lock[i]  = 1'b0;
                end
            end
        end
    end

    // ---------------- UART responder ----------------
    int lat    = 3;
    bit resp_en = 1'b1;
    bit spur   = 1'b0;
    int pend   = 0;

    initial begin
        uart_done = 1'b0;
        forever begin
            @(posedge clock); #1;
            uart_done = 1'b0;
            if (reset) pend = 0;
            else if (pend > 0) begin
                pend--;
                if (pend == 0) uart_done = 1'b1;
            end
            if (spur) begin
                uart_done = 1'b1;
                spur = 1'b0;
            end
            if (uart_send && resp_en && !reset) pend = lat;
        end
    end

    // ---------------- reference model ----------------
    function automatic int rr(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    int           ecnt = 0;
    bit           live = 1'b0;
    bit           m_wait = 1'b0, m_lock = 1'b0, m_lacc = 1'b0;
    int           m_owner = 0, m_ptr = 0, m_send_e = 0, m_free = 0;
    logic [N-1:0] e_ready = '0, e_done = '0;
    logic         e_send = 1'b0, e_busy = 1'b0, e_terr = 1'b0;
    logic [7:0]   e_data = '0;
    bit           e_data_chk = 1'b0;

    // m_free: edge number after which the arbiter is idle again; it may
    // accept at any later edge.
    initial forever begin
        @(posedge clock);
        ecnt++;
        e_ready = '0; e_done = '0; e_send = 1'b0; e_terr = 1'b0;
        if (reset) begin
            live = 1'b1; m_wait = 1'b0; m_ptr = 0; m_lock = 1'b0; m_free = ecnt;
            e_busy = 1'b0; e_data = '0; e_data_chk = 1'b1;
        end else if (!live) begin
            e_busy = 1'b0;
        end else if (m_wait) begin
            if (uart_done) begin
                e_done[m_owner] = 1'b1;
                if (m_lacc) m_lock = 1'b1;
                else begin
                    m_lock = 1'b0;
                    m_ptr = (m_owner + 1) % N;
                end
                m_wait = 1'b0; m_free = ecnt + GAP; e_busy = (GAP > 0); e_data_chk = 1'b0;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (ecnt - m_send_e == TMO) begin
                e_terr = 1'b1; m_lock = 1'b0; m_ptr = (m_owner + 1) % N;
                m_wait = 1'b0; m_free = ecnt; e_busy = 1'b0; e_data_chk = 1'b0;
            end
`endif
        end else if (ecnt > m_free) begin
            if (m_lock && !req_valid[m_owner]) m_lock = 1'b0;
            if (req_valid != '0) begin
                m_owner = m_lock ? m_owner : rr(req_valid, m_ptr);
                m_lacc = req_lock[m_owner];
                e_ready[m_owner] = 1'b1; e_send = 1'b1; e_busy = 1'b1;
                e_data = req_data[8*m_owner +: 8]; e_data_chk = 1'b1;
                m_wait = 1'b1; m_send_e = ecnt;
            end else begin
                e_busy = 1'b0;
            end
        end else begin
            e_busy = (ecnt < m_free);
        end
    end

    // ---------------- compare + logging ----------------
    int glog [64];
    int gn = 0;
    int ncyc = 0, last_done = 0, gapdiff = 0;

    initial forever begin
        @(negedge clock);
        ncyc++;
        if (live) begin
            check("busy", busy, e_busy);
            check("uart_send", uart_send, e_send);
            check("req_ready", req_ready, e_ready);
            check("req_done", req_done, e_done);
            check("timeout_err", timeout_err, e_terr);
            if (e_data_chk) check("uart_data", uart_data, e_data);
        end
        for (int i = 0; i < N; i++) if (req_ready[i] && gn < 64) begin
            glog[gn] = i;
            gn++;
        end
        if (uart_done) last_done = ncyc;
        if (uart_send) gapdiff = ncyc - last_done;
    end

    task automatic drain(input string name);
        int n = 0;
        while ((pending() || busy) && n < 300) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(n < 300), 1);
    endtask

    task automatic check_order(input string name, input int exp[], input int cnt);
        check({name, "_count"}, gn, cnt);
        for (int k = 0; k < cnt && k < gn; k++) check(name, glog[k], exp[k]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        int o2[] = '{0, 1, 2, 3, 0};
        int o3[] = '{1, 1, 1, 2, 0};
        int o3b[] = '{0, 0, 1};
        int o5[] = '{0, 3};

        g_valid = '0; g_lock = '0; g_data = '0; g_done = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_data", uart_data, 8'h00);
        check("rst_ready", req_ready, 0);
        reset = 1'b0;

        // 1: single byte from requester 1
        push(1, 1'b0, 8'h40);
        n = 0; while (!req_valid[1] && n < 10) begin @(negedge clock); n++; end
        n = 0; while (!uart_send && n < 10) begin @(negedge clock); n++; end
        check("t1_latency", n, 1);
        check("t1_data", uart_data, 8'h40);
        check("t1_ready", req_ready, 4'b0010);
        check("t1_busy", busy, 1);
        n = 0; while (req_done == '0 && n < 20) begin @(negedge clock); n++; end
        check("t1_done", req_done, 4'b0010);
        check("t1_busy_low", busy, 0);

        // 2: contention from reset
        reset = 1'b1; @(negedge clock); reset = 1'b0;
        gn = 0;
        push(0, 1'b0, 8'h11); push(1, 1'b0, 8'h21); push(2, 1'b0, 8'h31);
        push(3, 1'b0, 8'h41); push(0, 1'b0, 8'h12);
        drain("t2_drain");
        check_order("t2_order", o2, 5);
        check("t2_b2b", gapdiff, 2);

        // 3: packet lock by requester 1 against 0 and 2
        gn = 0;
        push(0, 1'b0, 8'hA0); push(2, 1'b0, 8'hC0);
        push(1, 1'b1, 8'hB1); push(1, 1'b1, 8'hB2); push(1, 1'b0, 8'hB3);
        drain("t3_drain");
        check_order("t3_order", o3, 5);

        // 3b: lock taken by a wrapped grant overrides the pointer
        gn = 0;
        push(0, 1'b1, 8'hD0);
        n = 0; while (!req_ready[0] && n < 20) begin @(negedge clock); n++; end
        push(1, 1'b0, 8'hE1); push(0, 1'b0, 8'hD1);
        drain("t3b_drain");
        check_order("t3b_order", o3b, 3);

        // 5: reset in the middle of a byte, then a stray done
        lat = 20;
        push(3, 1'b0, 8'h77);
        n = 0; while (!uart_send && n < 20) begin @(negedge clock); n++; end
        repeat (2) @(negedge clock);
        reset = 1'b1; @(negedge clock); reset = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_send", uart_send, 0);
        check("t5_data", uart_data, 8'h00);
        spur = 1'b1;
        repeat (4) @(negedge clock);
        check("t5_spur_busy", busy, 0);
        lat = 3; gn = 0;
        push(0, 1'b0, 8'h01); push(3, 1'b0, 8'h03);
        drain("t5_drain");
        check_order("t5_order", o5, 2);

        // 4: inter-byte gap on the GAP_CYCLES=5 instance
        g_valid = 4'b0011; g_data = 32'h0000_2211;
        n = 0; while (!g_send && n < 10) begin @(negedge clock); n++; end
        check("t4_send1", g_send, 1);
        check("t4_data1", g_udata, 8'h11);
        g_valid = g_valid & ~g_ready;
        repeat (3) @(negedge clock);
        g_done = 1'b1; @(negedge clock); g_done = 1'b0;
        check("t4_done1", g_done_o, 4'b0001);
        check("t4_busy_gap", g_busy, 1);
        n = 1; while (!g_send && n < 40) begin @(negedge clock); n++; end
        check("t4_gap", n, 7);
        check("t4_data2", g_udata, 8'h22);
        g_valid = g_valid & ~g_ready;
        repeat (2) @(negedge clock);
        g_done = 1'b1; @(negedge clock); g_done = 1'b0;
        check("t4_done2", g_done_o, 4'b0010);

`ifdef UART_ARB_TIMEOUT_EN
        // 6: watchdog abort
        resp_en = 1'b0;
        push(2, 1'b0, 8'h99);
        n = 0; while (!uart_send && n < 20) begin @(negedge clock); n++; end
        n = 0; while (!timeout_err && n < 150) begin @(negedge clock); n++; end
        check("t6_timeout", n, TMO);
        resp_en = 1'b1;
        push(1, 1'b0, 8'h55);
        drain("t6_drain");
`endif

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
